// File: rtl/alu_scheduler_pkg.sv
// Shared types and widths for the ALU scheduler slice.
package alu_sched_pkg;
    localparam int DATA_W  = 8;
    localparam int RES_W   = 9;
    localparam int SEL_W   = 2;
    localparam int NUM_REQ = 2;
    localparam int WAIT_W  = 4;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
endpackage

// File: rtl/alu_scheduler_if.sv
// Request/response and ALU-side bundle between clients, scheduler and the shared ALU.
interface alu_sched_if;
    import alu_sched_pkg::*;

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0][SEL_W-1:0]  req_sel;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_a;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0]             rsp_valid;
    logic [RES_W-1:0]               rsp_c;
    logic [SEL_W-1:0]               alu_sel;
    logic [DATA_W-1:0]              alu_a;
    logic [DATA_W-1:0]              alu_b;
    logic [RES_W-1:0]               alu_c;
    logic                           busy;
    logic                           grant_id;

    modport master (
        output req_valid, req_sel, req_a, req_b, alu_c,
        input  req_ready, rsp_valid, rsp_c, alu_sel, alu_a, alu_b, busy, grant_id
    );
    modport slave (
        input  req_valid, req_sel, req_a, req_b, alu_c,
        output req_ready, rsp_valid, rsp_c, alu_sel, alu_a, alu_b, busy, grant_id
    );
endinterface

// File: rtl/alu_scheduler_rr_arbiter_2.sv
// Two-way round-robin pick; on a tie the requester other than last_grant wins.
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       grant_id
);
    always_comb begin
        grant_id = 1'b0;
        case (req)
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~last_grant;
            default: grant_id = 1'b0;
        endcase
        grant = '0;
        if (|req) grant[grant_id] = 1'b1;
    end
endmodule

// File: rtl/alu_scheduler.sv
// Shares one combinational ALU between two requesters: accept, hold operands
// for WAIT_CYC+1 cycles, capture the result and pulse it back to the owner.
module alu_scheduler
    import alu_sched_pkg::*;
#(
    parameter int WAIT_CYC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_sched_if.slave  bus
);
    localparam logic [WAIT_W-1:0] WAIT_LD = WAIT_W'(WAIT_CYC);

    state_t              state, state_nxt;
    logic [WAIT_W-1:0]   cnt;
    logic                last_grant;
    logic                gid;
    logic [1:0]          grant;
    logic                accept;
    logic                grant_id_q;
    logic                busy_q;
    logic [1:0]          rsp_valid_q;
    logic [RES_W-1:0]    rsp_c_q;
    logic [SEL_W-1:0]    sel_q;
    logic [DATA_W-1:0]   a_q, b_q;

    rr_arbiter_2 u_arb (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_id   (gid)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: if (|bus.req_valid) begin
                accept    = 1'b1;
                state_nxt = EXEC;
            end
            EXEC: if (cnt == '0) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.req_ready = accept ? grant : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            last_grant  <= 1'b1;
            grant_id_q  <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= '0;
            rsp_c_q     <= '0;
            sel_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
        end else begin
            state       <= state_nxt;
            busy_q      <= (state_nxt != IDLE);
            rsp_valid_q <= '0;
            if (accept) begin
                sel_q      <= bus.req_sel[gid];
                a_q        <= bus.req_a[gid];
                b_q        <= bus.req_b[gid];
                grant_id_q <= gid;
                cnt        <= WAIT_LD;
            end
            if (state == EXEC) begin
                if (cnt == '0) begin
                    rsp_c_q                 <= bus.alu_c;
                    rsp_valid_q[grant_id_q] <= 1'b1;
                end else begin
                    cnt <= cnt - WAIT_W'(1);
                end
            end
            // Round-robin history only advances once the operation completes.
            if (state == DONE) last_grant <= grant_id_q;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_c     = rsp_c_q;
    assign bus.alu_sel   = sel_q;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.busy      = busy_q;
    assign bus.grant_id  = grant_id_q;
endmodule

// File: tb/tb_alu_scheduler.sv
// Two schedulers (settle 1 and 0) driven by per-requester drivers and checked
// every cycle against a cycle-schedule model, plus directed literal checks.
module tb_alu_scheduler;
    import alu_sched_pkg::*;

    localparam int W0 = 1;
    localparam int W1 = 0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_sched_if bus0 ();
    alu_sched_if bus1 ();

    alu_scheduler #(.WAIT_CYC(W0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    alu_scheduler #(.WAIT_CYC(W1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // ALU stub: add regardless of sel
    assign bus0.alu_c = {1'b0, bus0.alu_a} + {1'b0, bus0.alu_b};
    assign bus1.alu_c = {1'b0, bus1.alu_a} + {1'b0, bus1.alu_b};

    logic [1:0] vld  [2];
    logic [1:0] sel  [2][2];
    logic [7:0] opa  [2][2];
    logic [7:0] opb  [2][2];
    logic [1:0] rdy_s[2];
    int         mode;
    int         cyc_n = 0;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         gq0[$];

    assign bus0.req_valid = vld[0];
    assign bus0.req_sel   = {sel[0][1], sel[0][0]};
    assign bus0.req_a     = {opa[0][1], opa[0][0]};
    assign bus0.req_b     = {opb[0][1], opb[0][0]};
    assign bus1.req_valid = vld[1];
    assign bus1.req_sel   = {sel[1][1], sel[1][0]};
    assign bus1.req_a     = {opa[1][1], opa[1][0]};
    assign bus1.req_b     = {opb[1][1], opb[1][0]};

    // Model: each DUT is a schedule of accept cycle, free cycle and held results.
    int         wcyc   [2];
    int         acc    [2];
    int         free_at[2];
    bit         last   [2];
    logic [8:0] cur_rc [2], pend_rc [2];
    logic [1:0] cur_sel[2], pend_sel[2];
    logic [7:0] cur_a  [2], pend_a  [2];
    logic [7:0] cur_b  [2], pend_b  [2];
    bit         cur_g  [2], pend_g  [2];

    task automatic cmp(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc %0d: got %0d expected %0d", nm, d, cyc_n, got, exp);
        end
    endtask

    task automatic model_reset(input int d);
        acc[d] = -1000; free_at[d] = 0; last[d] = 1'b1;
        cur_rc[d] = '0; cur_sel[d] = '0; cur_a[d] = '0; cur_b[d] = '0; cur_g[d] = 1'b0;
        pend_rc[d] = '0; pend_sel[d] = '0; pend_a[d] = '0; pend_b[d] = '0; pend_g[d] = 1'b0;
    endtask

    task automatic chk(input int d, input logic [1:0] rdy, input logic [1:0] rv, input logic [8:0] rc,
                       input logic [1:0] asel, input logic [7:0] aa, input logic [7:0] ab,
                       input logic bsy, input logic gidv);
        int c;
        logic [1:0] er, erv;
        bit win;
        c = cyc_n;
        rdy_s[d] = rdy;
        if (!rst_n) begin
            cmp("rst_rsp_valid", d, rv, 0);
            cmp("rst_rsp_c", d, rc, 0);
            cmp("rst_busy", d, bsy, 0);
            cmp("rst_grant_id", d, gidv, 0);
            cmp("rst_alu_abs", d, {asel, aa, ab}, 0);
            model_reset(d);
            return;
        end
        if (c == acc[d] + 1) begin
            cur_g[d] = pend_g[d]; cur_sel[d] = pend_sel[d]; cur_a[d] = pend_a[d]; cur_b[d] = pend_b[d];
        end
        if (c == acc[d] + wcyc[d] + 2) cur_rc[d] = pend_rc[d];
        er = 2'b00;
        win = 1'b0;
        if (c >= free_at[d] && vld[d] != 2'b00) begin
            win = (vld[d] == 2'b11) ? !last[d] : vld[d][1];
            er[win] = 1'b1;
        end
        erv = 2'b00;
        if (c == acc[d] + wcyc[d] + 2) erv[cur_g[d]] = 1'b1;
        cmp("req_ready", d, rdy, er);
        cmp("busy", d, bsy, (c > acc[d] && c <= acc[d] + wcyc[d] + 2));
        cmp("rsp_valid", d, rv, erv);
        cmp("rsp_c", d, rc, cur_rc[d]);
        cmp("grant_id", d, gidv, cur_g[d]);
        cmp("alu_ops", d, {asel, aa, ab}, {cur_sel[d], cur_a[d], cur_b[d]});
        cmp("ready_while_busy", d, (|rdy) && bsy, 0);
        if (er != 2'b00) begin
            acc[d] = c; free_at[d] = c + wcyc[d] + 3; last[d] = win;
            pend_g[d] = win; pend_sel[d] = sel[d][win];
            pend_a[d] = opa[d][win]; pend_b[d] = opb[d][win];
            pend_rc[d] = {1'b0, opa[d][win]} + {1'b0, opb[d][win]};
            if (d == 0) gq0.push_back(int'(win));
        end
    endtask

    always @(posedge clk) cyc_n++;

    always @(negedge clk) begin
        chk(0, bus0.req_ready, bus0.rsp_valid, bus0.rsp_c, bus0.alu_sel, bus0.alu_a, bus0.alu_b, bus0.busy, bus0.grant_id);
        chk(1, bus1.req_ready, bus1.rsp_valid, bus1.rsp_c, bus1.alu_sel, bus1.alu_a, bus1.alu_b, bus1.busy, bus1.grant_id);
    end

    task automatic post(input int d, input int i, input logic [1:0] s, input logic [7:0] a, input logic [7:0] b);
        sel[d][i] = s; opa[d][i] = a; opb[d][i] = b; vld[d][i] = 1'b1;
    endtask

    task automatic post_rand(input int d, input int i);
        logic [7:0] a, b;
        a = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        b = 8'($urandom);
        post(d, i, 2'($urandom), a, b);
    endtask

    // Requester drivers: drop valid after a handshake, optionally reissue.
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 2; i++) begin
                if (vld[d][i] && rdy_s[d][i]) begin
                    vld[d][i] = 1'b0;
                    if (mode == 1) post_rand(d, i);
                end else if (mode == 2) begin
                    if (!vld[d][i]) begin
                        if ($urandom_range(0, 99) < 40) post_rand(d, i);
                    end else if ($urandom_range(0, 99) < 5) begin
                        vld[d][i] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic at(input int c);
        do @(negedge clk); while (cyc_n < c);
        #1;
    endtask

    task automatic clear_vld();
        vld[0] = 2'b00; vld[1] = 2'b00;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0; clear_vld();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    int t;

    initial begin
        wcyc[0] = W0; wcyc[1] = W1;
        model_reset(0); model_reset(1);
        mode = 0;
        rdy_s[0] = 2'b00; rdy_s[1] = 2'b00;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 2; i++) begin
                sel[d][i] = '0; opa[d][i] = '0; opb[d][i] = '0;
            end
        clear_vld();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Sole requester 0: 25 + 10
        @(posedge clk); #2;
        post(0, 0, 2'b00, 8'd25, 8'd10); post(1, 0, 2'b00, 8'd25, 8'd10);
        t = cyc_n;
        at(t);     cmp("A_ready", 0, bus0.req_ready, 2'b01);
        at(t + 1); cmp("A_busy_t1", 0, bus0.busy, 1);
        at(t + 2); cmp("A_w0_rsp_valid", 1, bus1.rsp_valid, 2'b01);
                   cmp("A_w0_rsp_c", 1, bus1.rsp_c, 35);
        at(t + 3); cmp("A_rsp_valid", 0, bus0.rsp_valid, 2'b01);
                   cmp("A_rsp_c", 0, bus0.rsp_c, 35);
                   cmp("A_busy_t3", 0, bus0.busy, 1);
        at(t + 4); cmp("A_busy_t4", 0, bus0.busy, 0);

        // Tie straight after reset: r0 (30+15) first, then r1 (200+100)
        do_reset();
        post(0, 0, 2'b01, 8'd30, 8'd15);  post(0, 1, 2'b10, 8'd200, 8'd100);
        post(1, 0, 2'b01, 8'd30, 8'd15);  post(1, 1, 2'b10, 8'd200, 8'd100);
        t = cyc_n;
        at(t);     cmp("B_ready0", 0, bus0.req_ready, 2'b01);
        at(t + 3); cmp("B_rsp0_valid", 0, bus0.rsp_valid, 2'b01);
                   cmp("B_rsp0_c", 0, bus0.rsp_c, 45);
                   cmp("B_w0_ready1", 1, bus1.req_ready, 2'b10);
        at(t + 4); cmp("B_ready1", 0, bus0.req_ready, 2'b10);
        at(t + 7); cmp("B_rsp1_valid", 0, bus0.rsp_valid, 2'b10);
                   cmp("B_rsp1_c", 0, bus0.rsp_c, 300);
                   cmp("B_rsp1_carry", 0, bus0.rsp_c[8], 1);

        // Both held valid: grants must alternate 0,1,0,1,0,1
        repeat (3) @(posedge clk);
        #2 gq0.delete();
        mode = 1;
        post_rand(0, 0); post_rand(0, 1); post_rand(1, 0); post_rand(1, 1);
        for (int k = 0; k < 100 && gq0.size() < 6; k++) @(posedge clk);
        #2 mode = 0; clear_vld();
        cmp("alt_count", 0, gq0.size() >= 6, 1);
        for (int k = 0; k < 6 && k < gq0.size(); k++) cmp("alt_grant", 0, gq0[k], k % 2);

        // Reset while in EXEC
        repeat (8) @(posedge clk);
        #2 post(0, 0, 2'b00, 8'd7, 8'd9); post(0, 1, 2'b00, 8'd3, 8'd4);
        t = cyc_n;
        at(t);     cmp("R_accept", 0, |bus0.req_ready, 1);
        at(t + 1); cmp("R_busy_pre", 0, bus0.busy, 1);
        rst_n = 1'b0; clear_vld();
        #1;
        cmp("R_busy", 0, bus0.busy, 0);
        cmp("R_rsp_c", 0, bus0.rsp_c, 0);
        cmp("R_alu_a", 0, bus0.alu_a, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        post(0, 0, 2'b00, 8'd1, 8'd2); post(0, 1, 2'b00, 8'd5, 8'd6);
        t = cyc_n;
        at(t);     cmp("R_tie_after_reset", 0, bus0.req_ready, 2'b01);
        at(t + 3); cmp("R_rsp_c_after", 0, bus0.rsp_c, 3);

        // Zero settle: 255 + 1 from requester 1
        repeat (6) @(posedge clk);
        #2 clear_vld();
        repeat (6) @(posedge clk);
        #2 post(1, 1, 2'b11, 8'd255, 8'd1);
        t = cyc_n;
        at(t);     cmp("Z_ready", 1, bus1.req_ready, 2'b10);
        at(t + 2); cmp("Z_rsp_valid", 1, bus1.rsp_valid, 2'b10);
                   cmp("Z_rsp_c", 1, bus1.rsp_c, 256);
        at(t + 3); cmp("Z_rsp_gone", 1, bus1.rsp_valid, 2'b00);
        at(t + 5); cmp("Z_rsp_hold", 1, bus1.rsp_c, 256);

        // Random traffic
        @(posedge clk); #2 mode = 2;
        repeat (400) @(posedge clk);
        #2 mode = 0; clear_vld();
        repeat (10) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
